// File: rtl/univ_shift_reg.sv
// Universal shift register with a built-in LSB-first serializer.
// In IDLE the register applies the operation selected by mode on each
// enabled edge; a start request loads D and shifts it out through sout_r
// over WIDTH enabled cycles, pulsing done on the final shift.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Serial outputs are taps on the registered contents.
  assign sout_l = Q[WIDTH-1];
  assign sout_r = Q[0];

  // Data register, serializer FSM, shift counter and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      Q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // done is a one-edge pulse: cleared on every edge, even when stalled.
      done <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (start) begin
              Q     <= D;
              cnt   <= '0;
              state <= SHIFT;
              busy  <= 1'b1;
            end else begin
              case (mode)
                MODE_HOLD: Q <= Q;
                MODE_SHL:  Q <= {Q[WIDTH-2:0], sin_r};
                MODE_SHR:  Q <= {sin_l, Q[WIDTH-1:1]};
                MODE_ROL:  Q <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                MODE_ROR:  Q <= {Q[0], Q[WIDTH-1:1]};
                MODE_LOAD: Q <= D;
                MODE_ASR:  Q <= {Q[WIDTH-1], Q[WIDTH-1:1]};
                MODE_CLR:  Q <= '0;
              endcase
            end
          end
          SHIFT: begin
            // mode and start are ignored until the last bit has left.
            Q   <= {sin_l, Q[WIDTH-1:1]};
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule
